mmio_uart_tx_port: RTL and testbench

// - Serial-transmit peripheral on one port pair of the MMIO controller.
// - Consumes the pair's latched output words plus its write-inform flag.
// - Buffers bytes in a FIFO and serialises them 8N1 (optionally 8E1) on tx.
// - Returns status/counter words on the pair's input lines for CPU reads.

---
 rtl/mmio_uart_tx_port.sv | 205 ++++++++++++++++++++
 tb/tb_mmio_uart_tx_port.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx_port.sv
// rtl/mmio_uart_tx_port.sv - MMIO port-pair UART transmitter with byte FIFO and status readback
// Optional feature: define MMIO_UART_PARITY_EN for 8E1 framing (default build is 8N1).

module mmio_uart_tx_port #(
  parameter int FIFO_DEPTH_EXP = 4,
  parameter int CLKS_PER_BIT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        port_inform_write,
  input  logic        port_inform_read,
  input  logic [15:0] port_d_out_even,
  input  logic [15:0] port_d_out_odd,
  output logic [15:0] port_d_in_even,
  output logic [15:0] port_d_in_odd,
  output logic        tx
);

  localparam int DEPTH = 1 << FIFO_DEPTH_EXP;
  localparam int PW    = FIFO_DEPTH_EXP + 1;
  localparam int BW    = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] FULL_COUNT = PW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          state;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift_reg;
  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   count;
  logic            wr_q;
  logic            rd_q;
  logic            ovf;
  logic [15:0]     drop_cnt;

  logic            wr_evt;
  logic            rd_evt;
  logic            enq;
  logic            flush;
  logic            empty;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;
  logic            baud_done;
  logic            unused_ok;

  // Only the data byte and the ENQ/FLUSH bits of the pair carry meaning.
  assign unused_ok = ^{port_d_out_even[15:8], port_d_out_odd[15:2]};

  assign wr_evt    = port_inform_write & ~wr_q;
  assign rd_evt    = port_inform_read & ~rd_q;
  assign enq       = wr_evt & port_d_out_odd[0];
  assign flush     = wr_evt & port_d_out_odd[1];

  assign count     = wr_ptr - rd_ptr;
  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign pop       = (state == S_IDLE) && !empty;
  // A flush frees the whole FIFO, and a same-cycle pop frees one slot.
  assign push      = enq && (flush || !full || pop);
  assign drop      = enq && !push;
  assign baud_done = (baud_cnt == BAUD_LAST);

  assign port_d_in_even = {4'b0000, ovf, (state != S_IDLE), full, empty, 8'(count)};
  assign port_d_in_odd  = drop_cnt;

  // Sample inform levels so only their rising edges generate events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      wr_q <= port_inform_write;
      rd_q <= port_inform_read;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[FIFO_DEPTH_EXP-1:0]] <= port_d_out_even[7:0];
    end
  end

  // FIFO pointers: flush collapses the read pointer onto the write pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Overflow flag and saturating dropped-byte counter; a new drop beats a read-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != 16'hFFFF) begin
          drop_cnt <= drop_cnt + 16'd1;
        end
      end else if (rd_evt) begin
        ovf <= 1'b0;
      end
    end
  end

  // Serialiser FSM: start, 8 data bits LSB first, optional even parity, stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      tx        <= 1'b1;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            shift_reg <= mem[rd_ptr[FIFO_DEPTH_EXP-1:0]];
            tx        <= 1'b0;
            state     <= S_START;
          end
        end
        S_START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift_reg[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
`ifdef MMIO_UART_PARITY_EN
              tx      <= ^shift_reg;
              state   <= S_PARITY;
`else
              tx      <= 1'b1;
              state   <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift_reg[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        S_PARITY: begin
          if (baud_done) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        S_STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx_port.sv
// tb/tb_mmio_uart_tx_port.sv - self-checking bench for mmio_uart_tx_port

module tb_mmio_uart_tx_port;

  localparam int DEXP  = 4;
  localparam int DEPTH = 1 << DEXP;
  localparam int CPB   = 6;
`ifdef MMIO_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        port_inform_write = 1'b0;
  logic        port_inform_read = 1'b0;
  logic [15:0] port_d_out_even = '0;
  logic [15:0] port_d_out_odd = '0;
  logic [15:0] port_d_in_even;
  logic [15:0] port_d_in_odd;
  logic        tx;

  int total = 0;
  int bad = 0;
  int frame_err = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  mmio_uart_tx_port #(.FIFO_DEPTH_EXP(DEXP), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .port_inform_write(port_inform_write),
    .port_inform_read(port_inform_read),
    .port_d_out_even(port_d_out_even),
    .port_d_out_odd(port_d_out_odd),
    .port_d_in_even(port_d_in_even),
    .port_d_in_odd(port_d_in_odd),
    .tx(tx)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = b;
`ifdef MMIO_UART_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  function automatic logic [15:0] make_status(input int cnt, input bit busy, input bit ov);
    logic [15:0] s;
    s = '0;
    s[7:0] = 8'(cnt);
    s[8] = (cnt == 0);
    s[9] = (cnt == DEPTH);
    s[10] = busy;
    s[11] = ov;
    return s;
  endfunction

  // Line monitor: decodes frames at bit centres, abandons a frame on reset.
  logic [7:0] mon_byte;
  logic       mon_start, mon_stop, mon_par;
  bit         mon_abort;

  task automatic mon_wait(input int n, inout bit ab);
    for (int i = 0; i < n && !ab; i++) begin
      @(negedge clk);
      if (rst) ab = 1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        mon_abort = 0;
        mon_par = 1'b0;
        mon_wait(CPB / 2, mon_abort);
        mon_start = tx;
        for (int i = 0; i < 8; i++) begin
          mon_wait(CPB, mon_abort);
          mon_byte[i] = tx;
        end
`ifdef MMIO_UART_PARITY_EN
        mon_wait(CPB, mon_abort);
        mon_par = tx ^ (^mon_byte);
`endif
        mon_wait(CPB, mon_abort);
        mon_stop = tx;
        if (!mon_abort) begin
          if (mon_start !== 1'b0 || mon_stop !== 1'b1 || mon_par !== 1'b0) frame_err++;
          rx_q.push_back(mon_byte);
        end
      end
    end
  end

  task automatic do_write(input logic [1:0] ctl, input logic [7:0] data);
    logic [31:0] r;
    r = $urandom;
    port_d_out_even = {r[15:8], data};
    port_d_out_odd = {r[31:18], ctl};
    port_inform_write = 1'b1;
    @(negedge clk);
    port_inform_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_drain(output bit ok);
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (port_d_in_even[10] == 1'b0 && port_d_in_even[8] == 1'b1) begin
        ok = 1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx); end
    total++; if (port_d_in_even !== 16'h0100) begin bad++; $display("FAIL reset_status got=%h want=0100", port_d_in_even); end
    total++; if (port_d_in_odd !== 16'h0000) begin bad++; $display("FAIL reset_drop got=%h want=0000", port_d_in_odd); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL idle_tx got=%b want=1", tx); end
    total++; if (port_d_in_even !== 16'h0100) begin bad++; $display("FAIL idle_status got=%h want=0100", port_d_in_even); end
    total++; if (port_d_in_odd !== 16'h0000) begin bad++; $display("FAIL idle_drop got=%h want=0000", port_d_in_odd); end
  endtask

  task automatic test_single_frame;
    logic [10:0] f;
    bit ok;
    f = frame_bits(8'hA5);
    rx_q.delete();
    port_d_out_even = 16'h00A5;
    port_d_out_odd = 16'h0001;
    port_inform_write = 1'b1;
    @(negedge clk);
    total++; if (port_d_in_even !== make_status(1, 0, 0)) begin bad++; $display("FAIL single_count got=%h want=%h", port_d_in_even, make_status(1, 0, 0)); end
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL single_tx_pre got=%b want=1", tx); end
    @(negedge clk);
    total++; if (port_d_in_even !== make_status(0, 1, 0)) begin bad++; $display("FAIL single_busy got=%h want=%h", port_d_in_even, make_status(0, 1, 0)); end
    for (int k = 0; k < NBITS * CPB; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) port_inform_write = 1'b0;
      total++;
      if (tx !== f[k / CPB]) begin bad++; $display("FAIL single_wave cycle=%0d got=%b want=%b", k, tx, f[k / CPB]); end
    end
    @(negedge clk);
    total++; if (port_d_in_even !== 16'h0100) begin bad++; $display("FAIL single_after got=%h want=0100", port_d_in_even); end
    wait_drain(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL single_drain got=timeout want=idle"); end
    total++; if (rx_q.size() !== 1) begin bad++; $display("FAIL single_pushes got=%0d want=1", rx_q.size()); end
    else begin
      total++; if (rx_q[0] !== 8'hA5) begin bad++; $display("FAIL single_byte got=%h want=a5", rx_q[0]); end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int n;
    logic [7:0] b;
    for (int it = 0; it < 4; it++) begin
      rx_q.delete();
      exp_q.delete();
      n = (it == 0) ? 16 : $urandom_range(1, 16);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        do_write(2'b01, b);
      end
      wait_drain(ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL b2b_drain iter=%0d got=timeout want=idle", it); end
      total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL b2b_len iter=%0d got=%0d want=%0d", it, rx_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
        total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_byte iter=%0d idx=%0d got=%h want=%h", it, i, rx_q[i], exp_q[i]); end
      end
    end
    total++; if (frame_err !== 0) begin bad++; $display("FAIL b2b_framing got=%0d want=0", frame_err); end
    total++; if (port_d_in_odd !== 16'h0000) begin bad++; $display("FAIL b2b_drop got=%h want=0000", port_d_in_odd); end
  endtask

  task automatic test_overflow;
    logic [7:0] b;
    rx_q.delete();
    exp_q.delete();
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      do_write(2'b01, b);
    end
    total++; if (port_d_in_even !== make_status(DEPTH, 1, 0)) begin bad++; $display("FAIL ovf_full got=%h want=%h", port_d_in_even, make_status(DEPTH, 1, 0)); end
    do_write(2'b01, 8'($urandom));
    total++; if (port_d_in_even !== make_status(DEPTH, 1, 1)) begin bad++; $display("FAIL ovf_flag got=%h want=%h", port_d_in_even, make_status(DEPTH, 1, 1)); end
    total++; if (port_d_in_odd !== 16'd1) begin bad++; $display("FAIL ovf_drop got=%0d want=1", port_d_in_odd); end
  endtask

  task automatic test_read_clear;
    port_inform_read = 1'b1;
    @(negedge clk);
    total++; if (port_d_in_even !== make_status(DEPTH, 1, 0)) begin bad++; $display("FAIL rdclr_status got=%h want=%h", port_d_in_even, make_status(DEPTH, 1, 0)); end
    total++; if (port_d_in_odd !== 16'd1) begin bad++; $display("FAIL rdclr_drop got=%0d want=1", port_d_in_odd); end
    @(negedge clk);
    port_inform_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ovf_priority;
    bit ok;
    port_d_out_even = 16'h0077;
    port_d_out_odd = 16'h0001;
    port_inform_write = 1'b1;
    port_inform_read = 1'b1;
    @(negedge clk);
    total++; if (port_d_in_even !== make_status(DEPTH, 1, 1)) begin bad++; $display("FAIL prio_status got=%h want=%h", port_d_in_even, make_status(DEPTH, 1, 1)); end
    total++; if (port_d_in_odd !== 16'd2) begin bad++; $display("FAIL prio_drop got=%0d want=2", port_d_in_odd); end
    port_inform_write = 1'b0;
    port_inform_read = 1'b0;
    wait_drain(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL ovf_drain got=timeout want=idle"); end
    total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL ovf_len got=%0d want=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL ovf_byte idx=%0d got=%h want=%h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_flush;
    bit ok;
    logic [7:0] b;
    rx_q.delete();
    exp_q.delete();
    b = 8'($urandom);
    exp_q.push_back(b);
    do_write(2'b01, b);
    for (int i = 0; i < 5; i++) do_write(2'b01, 8'($urandom));
    total++; if (port_d_in_even !== make_status(5, 1, 1)) begin bad++; $display("FAIL flush_pre got=%h want=%h", port_d_in_even, make_status(5, 1, 1)); end
    b = 8'($urandom);
    exp_q.push_back(b);
    do_write(2'b11, b);
    total++; if (port_d_in_even !== make_status(1, 1, 1)) begin bad++; $display("FAIL flush_post got=%h want=%h", port_d_in_even, make_status(1, 1, 1)); end
    wait_drain(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL flush_drain got=timeout want=idle"); end
    total++; if (rx_q.size() !== 2) begin bad++; $display("FAIL flush_len got=%0d want=2", rx_q.size()); end
    for (int i = 0; i < 2 && i < rx_q.size(); i++) begin
      total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL flush_byte idx=%0d got=%h want=%h", i, rx_q[i], exp_q[i]); end
    end
    total++; if (frame_err !== 0) begin bad++; $display("FAIL flush_framing got=%0d want=0", frame_err); end
  endtask

  task automatic test_reset_midframe;
    bit ok;
    bit seen;
    logic [10:0] f;
    rx_q.delete();
    do_write(2'b01, 8'h00);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx === 1'b0) begin seen = 1; break; end
      @(negedge clk);
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL rstmid_start got=timeout want=start"); end
    do_write(2'b01, 8'h3C);
    repeat (5 * CPB + CPB / 2 - 2) @(negedge clk);
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL rstmid_bit4 got=%b want=0", tx); end
    total++; if (port_d_in_even !== make_status(1, 1, 1)) begin bad++; $display("FAIL rstmid_pre got=%h want=%h", port_d_in_even, make_status(1, 1, 1)); end
    #2 rst = 1'b1;
    #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL rstmid_tx got=%b want=1", tx); end
    total++; if (port_d_in_even !== 16'h0100) begin bad++; $display("FAIL rstmid_status got=%h want=0100", port_d_in_even); end
    total++; if (port_d_in_odd !== 16'h0000) begin bad++; $display("FAIL rstmid_drop got=%h want=0000", port_d_in_odd); end
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (port_d_in_even !== 16'h0100) begin bad++; $display("FAIL rstmid_lost got=%h want=0100", port_d_in_even); end
    rx_q.delete();
    f = frame_bits(8'h00);
    do_write(2'b01, 8'h00);
    for (int k = 0; k < NBITS * CPB; k++) begin
      if (k > 0) @(negedge clk);
      total++;
      if (tx !== f[k / CPB]) begin bad++; $display("FAIL rstmid_wave cycle=%0d got=%b want=%b", k, tx, f[k / CPB]); end
    end
    wait_drain(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rstmid_drain got=timeout want=idle"); end
    total++; if (rx_q.size() !== 1) begin bad++; $display("FAIL rstmid_len got=%0d want=1", rx_q.size()); end
    else begin
      total++; if (rx_q[0] !== 8'h00) begin bad++; $display("FAIL rstmid_byte got=%h want=00", rx_q[0]); end
    end
    total++; if (frame_err !== 0) begin bad++; $display("FAIL rstmid_framing got=%0d want=0", frame_err); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_read_clear();
    test_ovf_priority();
    test_flush();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
